// File: rtl/cdc_handshake_tx_if.sv
// cdc_handshake_tx_if: local valid/ready word port plus the req/ack/data bus crossing to the remote domain
interface cdc_handshake_tx_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_req;
  logic             xfer_ack;
  logic             tx_done;
  logic             busy;
  modport master (output in_valid, in_data, xfer_ack, input in_ready, xfer_data, xfer_req, tx_done, busy);
  modport slave (input in_valid, in_data, xfer_ack, output in_ready, xfer_data, xfer_req, tx_done, busy);
endinterface

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source end of a 4-phase req/ack bus crossing; CDC_HANDSHAKE_TX_STATS_EN adds transfer count/latency outputs
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              din_clk,
  input logic              din_rst_n,
  cdc_handshake_tx_if.slave bus
`ifdef CDC_HANDSHAKE_TX_STATS_EN
  ,
  output logic [15:0]      xfer_count,
  output logic [15:0]      xfer_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s, accept, req_d, done_d;
  logic [WIDTH-1:0]       data_d;
  assign ack_s        = ack_sync[SYNC_STAGES-1];
  assign bus.in_ready = (state == IDLE) && !ack_s;
  assign bus.busy     = state != IDLE;
  assign accept       = bus.in_valid && bus.in_ready;
  // bring the remote ack level into din_clk before the FSM looks at it
  always_ff @(posedge din_clk)
    if (!din_rst_n) ack_sync <= '0;
    else ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.xfer_ack};
  // state and the registered bus outputs; reset aborts any transfer in flight
  always_ff @(posedge din_clk)
    if (!din_rst_n) begin
      state         <= IDLE;
      bus.xfer_req  <= 1'b0;
      bus.xfer_data <= '0;
      bus.tx_done   <= 1'b0;
    end else begin
      state         <= state_d;
      bus.xfer_req  <= req_d;
      bus.xfer_data <= data_d;
      bus.tx_done   <= done_d;
    end
  // data and req are launched together on acceptance; data is frozen until back in IDLE
  always_comb begin
    state_d = state;
    req_d   = bus.xfer_req;
    data_d  = bus.xfer_data;
    done_d  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_d = REQ;
        req_d   = 1'b1;
        data_d  = bus.in_data;
      end
      REQ: if (ack_s) begin
        state_d = RELEASE;
        req_d   = 1'b0;
        done_d  = 1'b1;
      end
      RELEASE: if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef CDC_HANDSHAKE_TX_STATS_EN
  logic [15:0] cyc;
  // cyc counts edges since acceptance, so it equals the accept-to-tx_done span when done fires
  always_ff @(posedge din_clk)
    if (!din_rst_n) begin
      cyc         <= '0;
      xfer_count  <= '0;
      xfer_cycles <= '0;
    end else begin
      if (accept) cyc <= 16'd1;
      else if (state == REQ && cyc != 16'hFFFF) cyc <= cyc + 16'd1;
      if (done_d) begin
        xfer_count  <= xfer_count + 16'd1;
        xfer_cycles <= cyc;
      end
    end
`endif
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed checks of two instances (2- and 3-stage ack sync) against a 3-cycle remote ack model
module tb_cdc_handshake_tx;
  logic din_clk = 1'b0;
  logic din_rst_n;
  logic [3:0] ha, hb;
  bit manual;
  int n_chk = 0, n_pass = 0;
  always #5 din_clk = ~din_clk;
  cdc_handshake_tx_if #(.WIDTH(8)) ifa ();
  cdc_handshake_tx_if #(.WIDTH(8)) ifb ();
`ifdef CDC_HANDSHAKE_TX_STATS_EN
  logic [15:0] cnt_a, cyc_a, cnt_b, cyc_b;
`endif
  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(2)) u_a (
    .din_clk(din_clk), .din_rst_n(din_rst_n), .bus(ifa)
`ifdef CDC_HANDSHAKE_TX_STATS_EN
    , .xfer_count(cnt_a), .xfer_cycles(cyc_a)
`endif
  );
  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(3)) u_b (
    .din_clk(din_clk), .din_rst_n(din_rst_n), .bus(ifb)
`ifdef CDC_HANDSHAKE_TX_STATS_EN
    , .xfer_count(cnt_b), .xfer_cycles(cyc_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one clock; the remote side raises/drops ack 3 edges after it sees req change
  task automatic step();
    @(posedge din_clk);
    #1;
    ha = {ha[2:0], ifa.xfer_req};
    hb = {hb[2:0], ifb.xfer_req};
    if (!manual) begin
      ifa.xfer_ack = ha[3];
      ifb.xfer_ack = hb[3];
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    ifa.in_valid = v;
    ifb.in_valid = v;
    ifa.in_data  = d;
    ifb.in_data  = d;
  endtask

  task automatic set_ack(input logic a);
    ifa.xfer_ack = a;
    ifb.xfer_ack = a;
  endtask

  initial begin
    int da, db, ra, rb, na, nb, sa, sb, qa, qb;
    bit bad;
    manual = 1'b0;
    ha = '0;
    hb = '0;
    din_rst_n = 1'b0;
    drive(1'b0, 8'h00);
    set_ack(1'b0);
    step();
    step();
    chk("rst_req", ifa.xfer_req, 0);
    chk("rst_data", ifa.xfer_data, 0);
    chk("rst_done", ifa.tx_done, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_ready", ifa.in_ready, 1);
    din_rst_n = 1'b1;
    step();

    // basic transfer on both instances, identical remote timing
    drive(1'b1, 8'hA5);
    step();
    drive(1'b0, 8'h00);
    chk("acc_req", ifa.xfer_req, 1);
    chk("acc_data", ifa.xfer_data, 8'hA5);
    chk("acc_busy", ifa.busy, 1);
    chk("acc_ready", ifa.in_ready, 0);
    da = 0; db = 0; ra = 0; rb = 0; na = 0; nb = 0; bad = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ifa.tx_done) begin na++; if (da == 0) da = k; end
      if (ifb.tx_done) begin nb++; if (db == 0) db = k; end
      if (ifa.in_ready && ra == 0) ra = k;
      if (ifb.in_ready && rb == 0) rb = k;
      if (ifa.xfer_data !== 8'hA5) bad = 1;
    end
    chk("done_at_s2", da, 6);
    chk("done_at_s3", db, 7);
    chk("done_cnt_s2", na, 1);
    chk("done_cnt_s3", nb, 1);
    chk("ready_at_s2", ra, 12);
    chk("ready_at_s3", rb, 14);
    chk("data_hold", bad, 0);

    // back-to-back with in_valid held high
    drive(1'b1, 8'h11);
    step();
    drive(1'b1, 8'h22);
    sa = 0; sb = 0; na = 0; bad = 0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (ifa.xfer_data == 8'h22 && sa == 0) sa = k;
      if (ifb.xfer_data == 8'h22 && sb == 0) sb = k;
      if (sa == 0 && ifa.xfer_data !== 8'h11) bad = 1;
      if (ifa.tx_done) na++;
      if (k == 15) drive(1'b0, 8'h00);
    end
    chk("b2b_second_s2", sa, 13);
    chk("b2b_second_s3", sb, 15);
    chk("b2b_first_hold", bad, 0);
    chk("b2b_done_cnt", na, 2);
    chk("b2b_idle", {ifa.busy, ifb.busy}, 0);

    // stale ack held high across reset release
    manual = 1'b1;
    set_ack(1'b1);
    din_rst_n = 1'b0;
    step();
    step();
    din_rst_n = 1'b1;
    step();
    step();
    step();
    drive(1'b1, 8'h5A);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (ifa.in_ready || ifa.xfer_req || ifb.in_ready || ifb.xfer_req) bad = 1;
    end
    chk("stale_blocked", bad, 0);
    set_ack(1'b0);
    ra = 0; qa = 0; qb = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (ifa.in_ready && ra == 0) ra = k;
      if (ifa.xfer_req && qa == 0) qa = k;
      if (ifb.xfer_req && qb == 0) qb = k;
    end
    drive(1'b0, 8'h00);
    chk("stale_ready_at", ra, 2);
    chk("stale_req_at_s2", qa, 3);
    chk("stale_req_at_s3", qb, 4);
    chk("stale_data", ifa.xfer_data, 8'h5A);

    // reset while both instances sit in REQ
    chk("pre_rst_req", ifa.xfer_req, 1);
    din_rst_n = 1'b0;
    step();
    chk("mid_rst_req", ifa.xfer_req, 0);
    chk("mid_rst_data", ifa.xfer_data, 0);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_done", ifa.tx_done, 0);
    chk("mid_rst_req_s3", ifb.xfer_req, 0);
    din_rst_n = 1'b1;
    ha = '0;
    hb = '0;
    manual = 1'b0;
    set_ack(1'b0);
    step();
    step();
    chk("post_rst_ready", ifa.in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
